// File: rtl/ula_multi.sv
// Keypad ALU: builds two decimal operands from key codes and computes
// ADD/SUB/MUL into a registered signed-magnitude result on EQUALS.
module ula_multi #(
  parameter int DIGITS = 2,
  parameter int OW     = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [7:0]        data,
  input  logic              validate,
  output logic [OW-1:0]     out_A,
  output logic [OW-1:0]     out_B,
  output logic [2*OW-1:0]   result,
  output logic              neg,
  output logic              on,
  output logic [2:0]        mode,
  output logic [1:0]        op,
  output logic              err
);

  // state     | meaning
  // S_OFF     | powered down, only ON_OFF is honoured
  // S_IDLE    | powered, no operand being edited
  // S_EDIT_A  | digits append to operand A
  // S_EDIT_B  | digits append to operand B
  // S_RESULT  | result registered after EQUALS
  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_IDLE   = 3'd1,
    S_EDIT_A = 3'd2,
    S_EDIT_B = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam int RW = 2 * OW;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  localparam logic [7:0] K_ADD    = 8'd10;
  localparam logic [7:0] K_SUB    = 8'd11;
  localparam logic [7:0] K_MUL    = 8'd12;
  localparam logic [7:0] K_EQUALS = 8'd14;
  localparam logic [7:0] K_DEF_A  = 8'd15;
  localparam logic [7:0] K_CLEAR  = 8'd16;
  localparam logic [7:0] K_ON_OFF = 8'd18;
  localparam logic [7:0] K_DEF_B  = 8'd19;

  state_t          state, state_n;
  logic [OW-1:0]   a_n, b_n;
  logic [CW-1:0]   cnt_a, cnt_b, cnt_a_n, cnt_b_n;
  logic [RW-1:0]   result_n;
  logic            neg_n, on_n, err_n;
  logic [1:0]      op_n;

  logic            v_s1, v_s2, v_hist;
  logic            key_evt;
  logic            is_digit;
  logic [OW-1:0]   digit;
  logic [RW-1:0]   a_ext, b_ext;
  logic [RW-1:0]   sum, prod, diff_ab, diff_ba;
  logic            a_ge_b;

  // validate is asynchronous: two-flop synchronizer, then edge detect
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      v_s1   <= 1'b0;
      v_s2   <= 1'b0;
      v_hist <= 1'b0;
    end else begin
      v_s1   <= validate;
      v_s2   <= v_s1;
      v_hist <= v_s2;
    end
  end

  assign key_evt  = v_s2 & ~v_hist;
  assign is_digit = (data <= 8'd9);
  assign digit    = OW'(data[3:0]);

  assign a_ext   = {{OW{1'b0}}, out_A};
  assign b_ext   = {{OW{1'b0}}, out_B};
  assign sum     = a_ext + b_ext;
  assign prod    = a_ext * b_ext;
  assign diff_ab = a_ext - b_ext;
  assign diff_ba = b_ext - a_ext;
  assign a_ge_b  = (out_A >= out_B);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_OFF;
      out_A  <= '0;
      out_B  <= '0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      result <= '0;
      neg    <= 1'b0;
      on     <= 1'b0;
      op     <= OP_NONE;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      out_A  <= a_n;
      out_B  <= b_n;
      cnt_a  <= cnt_a_n;
      cnt_b  <= cnt_b_n;
      result <= result_n;
      neg    <= neg_n;
      on     <= on_n;
      op     <= op_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    a_n      = out_A;
    b_n      = out_B;
    cnt_a_n  = cnt_a;
    cnt_b_n  = cnt_b;
    result_n = result;
    neg_n    = neg;
    on_n     = on;
    op_n     = op;
    err_n    = err;

    if (key_evt) begin
      if (state == S_OFF) begin
        if (data == K_ON_OFF) begin
          a_n      = '0;
          b_n      = '0;
          cnt_a_n  = '0;
          cnt_b_n  = '0;
          result_n = '0;
          neg_n    = 1'b0;
          op_n     = OP_NONE;
          err_n    = 1'b0;
          on_n     = 1'b1;
          state_n  = S_IDLE;
        end
      end else if (is_digit) begin
        // a digit is only accepted while its operand still has room
        if (state == S_EDIT_A) begin
          if (cnt_a < CW'(DIGITS)) begin
            a_n     = out_A * OW'(10) + digit;
            cnt_a_n = cnt_a + CW'(1);
            err_n   = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end else if (state == S_EDIT_B) begin
          if (cnt_b < CW'(DIGITS)) begin
            b_n     = out_B * OW'(10) + digit;
            cnt_b_n = cnt_b + CW'(1);
            err_n   = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          err_n = 1'b1;
        end
      end else begin
        case (data)
          K_ADD: begin
            op_n  = OP_ADD;
            err_n = 1'b0;
          end
          K_SUB: begin
            op_n  = OP_SUB;
            err_n = 1'b0;
          end
          K_MUL: begin
            op_n  = OP_MUL;
            err_n = 1'b0;
          end
          K_EQUALS: begin
            if (op == OP_NONE) begin
              err_n = 1'b1;
            end else begin
              err_n   = 1'b0;
              state_n = S_RESULT;
              neg_n   = 1'b0;
              case (op)
                OP_ADD:  result_n = sum;
                OP_SUB: begin
                  result_n = a_ge_b ? diff_ab : diff_ba;
                  neg_n    = ~a_ge_b;
                end
                default: result_n = prod;
              endcase
            end
          end
          K_DEF_A: begin
            a_n     = '0;
            cnt_a_n = '0;
            err_n   = 1'b0;
            state_n = S_EDIT_A;
          end
          K_DEF_B: begin
            b_n     = '0;
            cnt_b_n = '0;
            err_n   = 1'b0;
            state_n = S_EDIT_B;
          end
          K_CLEAR: begin
            a_n      = '0;
            b_n      = '0;
            cnt_a_n  = '0;
            cnt_b_n  = '0;
            result_n = '0;
            neg_n    = 1'b0;
            op_n     = OP_NONE;
            err_n    = 1'b0;
            state_n  = S_IDLE;
          end
          K_ON_OFF: begin
            a_n      = '0;
            b_n      = '0;
            cnt_a_n  = '0;
            cnt_b_n  = '0;
            result_n = '0;
            neg_n    = 1'b0;
            op_n     = OP_NONE;
            err_n    = 1'b0;
            on_n     = 1'b0;
            state_n  = S_OFF;
          end
          default: err_n = 1'b1;
        endcase
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_ula_multi.sv
// Drives the same key stream into a DIGITS=2/OW=8 and a DIGITS=3/OW=10
// instance and compares every output against a per-instance key model.
module tb_ula_multi;

  logic        CLOCK_50;
  logic        reset_n;
  logic [7:0]  data;
  logic        validate;

  logic [7:0]  a0, b0;
  logic [15:0] r0;
  logic        n0, on0, e0;
  logic [2:0]  md0;
  logic [1:0]  op0;

  logic [9:0]  a1, b1;
  logic [19:0] r1;
  logic        n1, on1, e1;
  logic [2:0]  md1;
  logic [1:0]  op1;

  int errors = 0;
  int checks = 0;

  ula_multi #(.DIGITS(2), .OW(8)) dut0 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .data(data), .validate(validate),
    .out_A(a0), .out_B(b0), .result(r0), .neg(n0), .on(on0),
    .mode(md0), .op(op0), .err(e0)
  );

  ula_multi #(.DIGITS(3), .OW(10)) dut1 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .data(data), .validate(validate),
    .out_A(a1), .out_B(b1), .result(r1), .neg(n1), .on(on1),
    .mode(md1), .op(op1), .err(e1)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int     mode;
    int     a;
    int     b;
    int     ca;
    int     cb;
    longint res;
    bit     neg;
    int     op;
    bit     err;
    bit     on;
  } mdl_t;

  mdl_t m[2];
  int   digs[2] = '{2, 3};

  function automatic void mdl_clear(int i);
    m[i] = '{mode: 0, a: 0, b: 0, ca: 0, cb: 0, res: 0, neg: 0, op: 0, err: 0, on: 0};
  endfunction

  function automatic void mdl_key(int i, int k);
    if (!m[i].on) begin
      if (k == 18) begin
        mdl_clear(i);
        m[i].on   = 1;
        m[i].mode = 1;
      end
      return;
    end
    if (k <= 9) begin
      if (m[i].mode == 2 && m[i].ca < digs[i]) begin
        m[i].a = m[i].a * 10 + k;
        m[i].ca++;
        m[i].err = 0;
      end else if (m[i].mode == 3 && m[i].cb < digs[i]) begin
        m[i].b = m[i].b * 10 + k;
        m[i].cb++;
        m[i].err = 0;
      end else begin
        m[i].err = 1;
      end
      return;
    end
    case (k)
      10, 11, 12: begin
        m[i].op  = k - 9;
        m[i].err = 0;
      end
      14: begin
        if (m[i].op == 0) m[i].err = 1;
        else begin
          m[i].err  = 0;
          m[i].mode = 4;
          m[i].neg  = 0;
          if (m[i].op == 1) m[i].res = longint'(m[i].a) + m[i].b;
          else if (m[i].op == 3) m[i].res = longint'(m[i].a) * m[i].b;
          else if (m[i].a >= m[i].b) m[i].res = m[i].a - m[i].b;
          else begin
            m[i].res = m[i].b - m[i].a;
            m[i].neg = 1;
          end
        end
      end
      15: begin
        m[i].a = 0; m[i].ca = 0; m[i].mode = 2; m[i].err = 0;
      end
      19: begin
        m[i].b = 0; m[i].cb = 0; m[i].mode = 3; m[i].err = 0;
      end
      16: begin
        mdl_clear(i);
        m[i].on   = 1;
        m[i].mode = 1;
      end
      18: mdl_clear(i);
      default: m[i].err = 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    chk({step, " d0.out_A"},  a0,  m[0].a);
    chk({step, " d0.out_B"},  b0,  m[0].b);
    chk({step, " d0.result"}, r0,  m[0].res);
    chk({step, " d0.neg"},    n0,  m[0].neg);
    chk({step, " d0.on"},     on0, m[0].on);
    chk({step, " d0.mode"},   md0, m[0].mode);
    chk({step, " d0.op"},     op0, m[0].op);
    chk({step, " d0.err"},    e0,  m[0].err);
    chk({step, " d1.out_A"},  a1,  m[1].a);
    chk({step, " d1.out_B"},  b1,  m[1].b);
    chk({step, " d1.result"}, r1,  m[1].res);
    chk({step, " d1.neg"},    n1,  m[1].neg);
    chk({step, " d1.on"},     on1, m[1].on);
    chk({step, " d1.mode"},   md1, m[1].mode);
    chk({step, " d1.op"},     op1, m[1].op);
    chk({step, " d1.err"},    e1,  m[1].err);
  endtask

  task automatic press(input int k, input int hi);
    @(negedge CLOCK_50);
    data     = 8'(k);
    validate = 1'b1;
    repeat (hi) @(negedge CLOCK_50);
    validate = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    mdl_key(0, k);
    mdl_key(1, k);
    check_all($sformatf("key%0d", k));
  endtask

  task automatic keys(input int ks[$]);
    foreach (ks[j]) press(ks[j], 3);
  endtask

  task automatic pulse_reset();
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    mdl_clear(0);
    mdl_clear(1);
    @(negedge CLOCK_50);
    check_all("reset_pulse");
  endtask

  int rnd_keys[12] = '{10, 11, 12, 14, 15, 19, 16, 18, 13, 17, 20, 255};

  initial begin
    reset_n  = 1'b0;
    validate = 1'b0;
    data     = 8'd0;
    mdl_clear(0);
    mdl_clear(1);
    repeat (3) @(negedge CLOCK_50);
    check_all("in_reset");
    reset_n = 1'b1;

    // power-up and digit rejection in IDLE
    keys('{3, 18, 5});
    // operand entry with overflow on the narrow instance
    keys('{15, 4, 2, 7, 19});
    keys('{19, 9, 9, 10, 14});
    keys('{11, 14, 12, 14});
    keys('{16, 14});
    // power off, then reset mid-entry
    keys('{18, 15, 4});
    keys('{18, 15, 4});
    pulse_reset();
    keys('{13, 18, 13});
    // three-digit operands
    keys('{15, 9, 9, 9, 19, 9, 9, 9, 12, 14});
    // minimum-width pulse and a long held level
    press(15, 2);
    press(7, 2);
    press(5, 25);
    press(11, 2);
    press(14, 40);

    for (int i = 0; i < 90; i++) begin
      int k;
      if ($urandom_range(0, 99) < 50) k = int'($urandom_range(0, 9));
      else k = rnd_keys[$urandom_range(0, 11)];
      if (!m[0].on && $urandom_range(0, 1) == 1) k = 18;
      press(k, int'($urandom_range(2, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
